// File: rtl/fpdiv_arbiter_pkg.sv
// Shared types for the fpdiv arbiter: FSM state encoding and the per-request mode bundle.
package fpdiv_arb_pkg;

    localparam int MODE_W = 7;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        RESP
    } state_t;

    typedef struct packed {
        logic [2:0] rm;
        logic       op_type;
        logic       P;
        logic       OvEn;
        logic       UnEn;
    } mode_t;

endpackage

// File: rtl/fpdiv_arbiter_rr_pick.sv
// Combinational round-robin find-first: first set request at or above ptr, wrapping past NREQ-1.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            found
);

    logic [IDW-1:0] j;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = '0;
        for (int i = 0; i < NREQ; i++) begin
            j = IDW'((int'(ptr) + i) % NREQ);
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = j;
            end
        end
    end

endmodule

// File: rtl/fpdiv_arbiter.sv
// Round-robin arbiter sharing one multi-cycle fpdiv between NREQ requesters.
// Define FPDIV_ARB_TIMEOUT_EN to build the WAIT-state watchdog that drives rsp_timeout.
module fpdiv_arbiter
    import fpdiv_arb_pkg::*;
#(
    parameter int NREQ           = 4,
    parameter int IDW            = 2,
    parameter int START_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [64*NREQ-1:0]   req_op1,
    input  logic [64*NREQ-1:0]   req_op2,
    input  logic [7*NREQ-1:0]    req_mode,
    output logic                 div_start,
    output logic [63:0]          div_op1,
    output logic [63:0]          div_op2,
    output logic [2:0]           div_rm,
    output logic                 div_op_type,
    output logic                 div_P,
    output logic                 div_OvEn,
    output logic                 div_UnEn,
    input  logic                 div_done,
    input  logic [63:0]          div_result,
    input  logic [4:0]           div_flags,
    input  logic                 div_denorm,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [63:0]          rsp_result,
    output logic [4:0]           rsp_flags,
    output logic                 rsp_denorm,
    output logic                 rsp_timeout
);

    localparam int CNT_MAX = (START_CYCLES > TIMEOUT_CYCLES) ? START_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_CYCLES - 1);

    state_t          state, next_state;
    logic [IDW-1:0]  rr_ptr, id_q, pick_idx;
    logic [NREQ-1:0] pick_grant;
    logic            pick_found;
    logic [CNT_W-1:0] cnt;
    mode_t           mode_q, pick_mode;
    logic [63:0]     op1_q, op2_q, result_q;
    logic [4:0]      flags_q;
    logic            denorm_q;
    logic            timeout_hit;

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign pick_mode = mode_t'(req_mode[pick_idx*MODE_W +: MODE_W]);

`ifdef FPDIV_ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic timeout_q;
    assign timeout_hit = (cnt == TIMEOUT_LAST);
    assign rsp_timeout = timeout_q;
`else
    assign timeout_hit = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // Grant is gated by reset_n so no requester sees a handshake while reset is held.
    always_comb begin
        next_state = state;
        req_ready  = '0;
        div_start  = 1'b0;
        rsp_valid  = 1'b0;
        unique case (state)
            IDLE: begin
                if (reset_n) req_ready = pick_grant;
                if (pick_found) next_state = START;
            end
            START: begin
                div_start = 1'b1;
                if (cnt == START_LAST) next_state = WAIT;
            end
            WAIT: begin
                if (div_done || timeout_hit) next_state = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // div_done is only sampled in WAIT, so a level left high by the previous op is harmless.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr   <= '0;
            id_q     <= '0;
            cnt      <= '0;
            mode_q   <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
            denorm_q <= 1'b0;
`ifdef FPDIV_ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_found) begin
                        op1_q  <= req_op1[pick_idx*64 +: 64];
                        op2_q  <= req_op2[pick_idx*64 +: 64];
                        mode_q <= pick_mode;
                        id_q   <= pick_idx;
                        cnt    <= '0;
`ifdef FPDIV_ARB_TIMEOUT_EN
                        timeout_q <= 1'b0;
`endif
                    end
                end
                START: begin
                    cnt <= (cnt == START_LAST) ? '0 : cnt + 1'b1;
                end
                WAIT: begin
                    if (div_done) begin
                        result_q <= div_result;
                        flags_q  <= div_flags;
                        denorm_q <= div_denorm;
                    end
`ifdef FPDIV_ARB_TIMEOUT_EN
                    else if (timeout_hit) begin
                        result_q  <= '0;
                        flags_q   <= '0;
                        denorm_q  <= 1'b0;
                        timeout_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready) rr_ptr <= (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign div_op1     = op1_q;
    assign div_op2     = op2_q;
    assign div_rm      = mode_q.rm;
    assign div_op_type = mode_q.op_type;
    assign div_P       = mode_q.P;
    assign div_OvEn    = mode_q.OvEn;
    assign div_UnEn    = mode_q.UnEn;
    assign rsp_id      = id_q;
    assign rsp_result  = result_q;
    assign rsp_flags   = flags_q;
    assign rsp_denorm  = denorm_q;

endmodule

// File: tb/tb_fpdiv_arbiter.sv
// Randomized self-checking bench for fpdiv_arbiter with a behavioural divider and round-robin model.
module tb_fpdiv_arbiter;

    localparam int NREQ  = 4;
    localparam int IDW   = 2;
    localparam int STC   = 2;
    localparam int TOC   = 8;

    logic                clk = 1'b0;
    logic                reset_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [64*NREQ-1:0]  req_op1, req_op2;
    logic [7*NREQ-1:0]   req_mode;
    logic                div_start;
    logic [63:0]         div_op1, div_op2;
    logic [2:0]          div_rm;
    logic                div_op_type, div_P, div_OvEn, div_UnEn;
    logic                div_done;
    logic [63:0]         div_result;
    logic [4:0]          div_flags;
    logic                div_denorm;
    logic                rsp_valid, rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [63:0]         rsp_result;
    logic [4:0]          rsp_flags;
    logic                rsp_denorm, rsp_timeout;

    logic [63:0] op1_arr  [NREQ];
    logic [63:0] op2_arr  [NREQ];
    logic [6:0]  mode_arr [NREQ];

    int checks   = 0;
    int failures = 0;
    int rr_model = 0;
    logic [63:0] obs_rsp_result;
    logic [IDW-1:0] obs_rsp_id;

    fpdiv_arbiter #(.NREQ(NREQ), .IDW(IDW), .START_CYCLES(STC), .TIMEOUT_CYCLES(TOC)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op1(req_op1), .req_op2(req_op2), .req_mode(req_mode),
        .div_start(div_start), .div_op1(div_op1), .div_op2(div_op2),
        .div_rm(div_rm), .div_op_type(div_op_type), .div_P(div_P),
        .div_OvEn(div_OvEn), .div_UnEn(div_UnEn),
        .div_done(div_done), .div_result(div_result), .div_flags(div_flags), .div_denorm(div_denorm),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_denorm(rsp_denorm),
        .rsp_timeout(rsp_timeout)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_op1[i*64 +: 64] = op1_arr[i];
            req_op2[i*64 +: 64] = op2_arr[i];
            req_mode[i*7 +: 7]  = mode_arr[i];
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Round-robin rule: first valid requester at or after the pointer, wrapping around.
    function automatic int modelPick();
        for (int i = 0; i < NREQ; i++)
            if (req_valid[(rr_model + i) % NREQ]) return (rr_model + i) % NREQ;
        return -1;
    endfunction

    task automatic newOps(input int i);
        op1_arr[i]  = {$urandom, $urandom};
        op2_arr[i]  = {$urandom, $urandom};
        mode_arr[i] = 7'($urandom);
    endtask

    task automatic applyStimulus();
        for (int i = 0; i < NREQ; i++) begin
            if (!req_valid[i]) begin
                if ($urandom_range(0, 1) == 1) begin
                    req_valid[i] = 1'b1;
                    newOps(i);
                end
            end else if ($urandom_range(0, 7) == 0) begin
                req_valid[i] = 1'b0;
            end
        end
        if (req_valid == '0) begin
            int r;
            r = $urandom_range(0, NREQ - 1);
            req_valid[r] = 1'b1;
            newOps(r);
        end
    endtask

    // One full operation: grant, start pulse, divider latency, held response, handshake.
    task automatic runOp(input int lat, input int hold, output int obs_grant);
        int exp_id, n;
        logic [63:0] e_res;
        logic [4:0]  e_flags;
        logic        e_den;
        #1;
        exp_id = modelPick();
        obs_grant = -1;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) obs_grant = i;
        if (exp_id < 0) begin
            checkOutput("grant_none", req_ready, 64'd0);
            return;
        end
        checkOutput("grant", req_ready, 64'd1 << exp_id);
        e_res   = $realtobits($bitstoreal(op1_arr[exp_id]) / $bitstoreal(op2_arr[exp_id]));
        e_flags = op1_arr[exp_id][4:0] ^ {mode_arr[exp_id][6:4], mode_arr[exp_id][1:0]};
        e_den   = op2_arr[exp_id][63] ^ op1_arr[exp_id][0];
        div_done   = 1'b1;
        div_result = {$urandom, $urandom};
        div_flags  = 5'($urandom);
        div_denorm = 1'($urandom);
        @(negedge clk);
        req_valid[exp_id] = 1'b0;
        checkOutput("op1", div_op1, op1_arr[exp_id]);
        checkOutput("op2", div_op2, op2_arr[exp_id]);
        checkOutput("mode", {div_rm, div_op_type, div_P, div_OvEn, div_UnEn}, mode_arr[exp_id]);
        checkOutput("ready_busy", req_ready, 64'd0);
        checkOutput("timeout_clr", rsp_timeout, 64'd0);
        n = 0;
        for (int k = 0; k < 10; k++) begin
            if (!div_start) break;
            checkOutput("early_rsp", rsp_valid, 64'd0);
            n++;
            @(negedge clk);
        end
        checkOutput("start_len", n, STC);
        div_done = 1'b0;
        for (int k = 0; k < lat; k++) begin
            @(negedge clk);
            checkOutput("wait_rsp", rsp_valid, 64'd0);
        end
        div_result = e_res;
        div_flags  = e_flags;
        div_denorm = e_den;
        div_done   = 1'b1;
        @(negedge clk);
        for (int k = 0; k <= hold; k++) begin
            checkOutput("rsp_valid", rsp_valid, 64'd1);
            checkOutput("rsp_id", rsp_id, exp_id);
            checkOutput("rsp_result", rsp_result, e_res);
            checkOutput("rsp_flags", rsp_flags, e_flags);
            checkOutput("rsp_denorm", rsp_denorm, e_den);
            checkOutput("rsp_timeout", rsp_timeout, 64'd0);
            checkOutput("no_grant_resp", req_ready, 64'd0);
            obs_rsp_id     = rsp_id;
            obs_rsp_result = rsp_result;
            if (k == hold) begin
                rsp_ready = 1'b1;
            end else begin
                div_result = {$urandom, $urandom};
                div_flags  = 5'($urandom);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        checkOutput("rsp_drop", rsp_valid, 64'd0);
        rr_model = (exp_id + 1) % NREQ;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: time limit reached got running expected finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int g;
        int order [5] = '{0, 1, 2, 3, 0};
        reset_n    = 1'b0;
        req_valid  = '1;
        rsp_ready  = 1'b0;
        div_done   = 1'b0;
        div_result = '0;
        div_flags  = '0;
        div_denorm = 1'b0;
        for (int i = 0; i < NREQ; i++) newOps(i);
        repeat (3) @(negedge clk);
        checkOutput("rst_ready", req_ready, 64'd0);
        checkOutput("rst_start", div_start, 64'd0);
        checkOutput("rst_rsp_valid", rsp_valid, 64'd0);
        checkOutput("rst_op1", div_op1, 64'd0);
        checkOutput("rst_result", rsp_result, 64'd0);
        checkOutput("rst_id", rsp_id, 64'd0);
        checkOutput("rst_timeout", rsp_timeout, 64'd0);
        req_valid = '0;
        reset_n   = 1'b1;
        @(negedge clk);

        $display("[TB] directed single request from requester 2");
        op1_arr[2]  = 64'h3FF0000000000000;
        op2_arr[2]  = 64'h4000000000000000;
        mode_arr[2] = 7'b001_0000;
        req_valid   = 4'b0100;
        runOp(2, 0, g);
        checkOutput("dir_grant", g, 2);
        checkOutput("dir_id", obs_rsp_id, 2);
        checkOutput("dir_result", obs_rsp_result, 64'h3FE0000000000000);

        $display("[TB] reset asserted while waiting for the divider");
        newOps(1);
        div_done  = 1'b0;
        req_valid = 4'b0010;
        #1;
        checkOutput("pre_rst_grant", req_ready, 64'b0010);
        @(negedge clk);
        req_valid = '0;
        repeat (STC) @(negedge clk);
        checkOutput("in_wait_start", div_start, 64'd0);
        checkOutput("in_wait_rsp", rsp_valid, 64'd0);
        reset_n   = 1'b0;
        req_valid = '1;
        #1;
        checkOutput("mid_rst_ready", req_ready, 64'd0);
        checkOutput("mid_rst_start", div_start, 64'd0);
        checkOutput("mid_rst_op1", div_op1, 64'd0);
        checkOutput("mid_rst_op2", div_op2, 64'd0);
        checkOutput("mid_rst_mode", {div_rm, div_op_type, div_P, div_OvEn, div_UnEn}, 64'd0);
        checkOutput("mid_rst_result", rsp_result, 64'd0);
        checkOutput("mid_rst_id", rsp_id, 64'd0);
        @(negedge clk);
        reset_n  = 1'b1;
        rr_model = 0;

        $display("[TB] all requesters valid continuously");
        for (int i = 0; i < NREQ; i++) newOps(i);
        for (int i = 0; i < 5; i++) begin
            runOp($urandom_range(0, 4), (i == 2) ? 5 : 0, g);
            checkOutput("rr_order", g, order[i]);
            for (int j = 0; j < NREQ; j++)
                if (!req_valid[j]) begin
                    req_valid[j] = 1'b1;
                    newOps(j);
                end
        end

        $display("[TB] randomized operations");
        for (int i = 0; i < 40; i++) begin
            applyStimulus();
            runOp($urandom_range(0, 5), $urandom_range(0, 3), g);
        end

`ifdef FPDIV_ARB_TIMEOUT_EN
        begin
            int n, e;
            $display("[TB] watchdog timeout");
            req_valid = '0;
            newOps(0);
            req_valid[0] = 1'b1;
            #1;
            e = modelPick();
            @(negedge clk);
            req_valid = '0;
            for (int k = 0; k < 10 && div_start; k++) @(negedge clk);
            div_done = 1'b0;
            n = 0;
            for (int k = 0; k < 20; k++) begin
                if (rsp_valid) break;
                n++;
                @(negedge clk);
            end
            checkOutput("to_wait_len", n, TOC);
            checkOutput("to_flag", rsp_timeout, 64'd1);
            checkOutput("to_result", rsp_result, 64'd0);
            checkOutput("to_flags", rsp_flags, 64'd0);
            checkOutput("to_denorm", rsp_denorm, 64'd0);
            checkOutput("to_id", rsp_id, e);
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            rr_model  = (e + 1) % NREQ;
            applyStimulus();
            runOp(1, 0, g);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
